// File: rtl/seg7_scan_display_if.sv
// Load/status bundle between a datapath result register
// and the seg7_scan_display driver.
interface seg7_scan_display_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              load;
  logic              hex_mode;
  logic              busy;
  logic              overflow;

  modport master (
    output data, load, hex_mode,
    input  busy, overflow
  );

  modport slave (
    input  data, load, hex_mode,
    output busy, overflow
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment driver with
// iterative double-dabble conversion or raw hex pass-through.
module seg7_scan_display #(
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 2000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_display_if.slave  bus,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int BW  = DIGITS * 4;
  localparam int DVW = $clog2(REFRESH_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = $clog2(DATA_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} st_t;

  st_t              st_q, st_d;
  logic [DVW-1:0]   div_q, div_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             scan_q, scan_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             flag_q, flag_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    disp_q, disp_d;

  logic             tick;
  logic [BW-1:0]    adj;
  logic [DIGITS-1:0] lz;
  logic             nz;
  logic [3:0]       dig;

  // Refresh divider; the first tick turns the scan on at digit 0.
  always_comb begin
    div_d  = div_q;
    idx_d  = idx_q;
    scan_d = scan_q;
    tick   = (div_q == DVW'(REFRESH_DIV - 1));
    if (tick) begin
      div_d  = '0;
      scan_d = 1'b1;
      if (scan_q)
        idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Load handling and one double-dabble step per SHIFT cycle.
  always_comb begin
    st_d   = st_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    flag_d = flag_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    adj    = bcd_q;
    unique case (st_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.hex_mode) begin
            disp_d = BW'(bus.data);
            ovf_d  = 1'b0;
          end else begin
            sh_d   = bus.data;
            bcd_d  = '0;
            cnt_d  = '0;
            flag_d = (64'(bus.data) >= LIMIT);
            busy_d = 1'b1;
            st_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        for (int k = 0; k < DIGITS; k++)
          if (adj[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1))
          st_d = COMMIT;
      end
      COMMIT: begin
        disp_d = bcd_q;
        ovf_d  = flag_q;
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      div_q  <= '0;
      idx_q  <= '0;
      scan_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      flag_q <= 1'b0;
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      scan_q <= scan_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      flag_q <= flag_d;
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
    end
  end

  // Render the active digit: dash, blank, or glyph.
  always_comb begin
    lz  = '0;
    nz  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz    = nz | (disp_q[4*k +: 4] != 4'd0);
      lz[k] = !nz && (k != 0);
    end
    dig = disp_q[4*idx_q +: 4];
    an  = '1;
    seg = 7'b1111111;
    dp  = 1'b1;
    if (scan_q) begin
      an = ~(DIGITS'(1) << idx_q);
      dp = ~dp_in[idx_q];
      if (ovf_q)
        seg = 7'b1111110;
      else if (BLANK_LZ != 0 && lz[idx_q])
        seg = 7'b1111111;
      else
        seg = hex7(dig);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: an 8-bit and a 16-bit
// instance, table vectors plus reset/ignore/abort sequences.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] dp_in;
  logic [3:0] an8, an16;
  logic [6:0] seg8, seg16;
  logic       dp8, dp16;

  seg7_scan_display_if #(.DATA_W(8))  b8 ();
  seg7_scan_display_if #(.DATA_W(16)) b16 ();

  seg7_scan_display #(
    .DATA_W(8), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) u8 (
    .clk(clk), .rst(rst), .bus(b8), .dp_in(dp_in),
    .an(an8), .seg(seg8), .dp(dp8)
  );

  seg7_scan_display #(
    .DATA_W(16), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) u16 (
    .clk(clk), .rst(rst), .bus(b16), .dp_in(dp_in),
    .an(an16), .seg(seg16), .dp(dp16)
  );

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000;

  logic       sel;
  logic [3:0] an_s;
  logic [6:0] seg_s;
  logic       dp_s, busy_s, ovf_s;

  always_comb begin
    an_s   = sel ? an16 : an8;
    seg_s  = sel ? seg16 : seg8;
    dp_s   = sel ? dp16 : dp8;
    busy_s = sel ? b16.busy : b8.busy;
    ovf_s  = sel ? b16.overflow : b8.overflow;
  end

  typedef struct {
    logic        s;
    logic        h;
    logic [15:0] d;
    logic [3:0]  dpi;
    logic [27:0] segs;
    logic        ovf;
    int          bz;
  } vec_t;

  typedef struct {
    logic        s;
    logic [27:0] segs;
    logic [3:0]  dpn;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[14];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic do_load(input logic s, input logic h,
                         input logic [15:0] d);
    @(negedge clk);
    sel = s;
    if (s) begin
      b16.data = d; b16.hex_mode = h; b16.load = 1'b1;
    end else begin
      b8.data = d[7:0]; b8.hex_mode = h; b8.load = 1'b1;
    end
    @(negedge clk);
    b8.load  = 1'b0;
    b16.load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_s === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (n >= 64) expired("busy_timeout");
  endtask

  task automatic check_disp(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      expired({nm, "_sb_empty"});
      return;
    end
    e = sbq.pop_front();
    sel = e.s;
    chk({nm, "_ovf"}, 32'(ovf_s), 32'(e.ovf));
    for (int i = 0; i < 4; i++) begin
      logic [3:0] want;
      int t;
      want = ~(4'b0001 << i);
      t = 0;
      while (an_s !== want && t < 64) begin
        t++;
        @(negedge clk);
      end
      if (t >= 64) begin
        expired($sformatf("%s_an%0d", nm, i));
      end else begin
        chk($sformatf("%s_seg%0d", nm, i),
            32'(seg_s), 32'(e.segs[i*7 +: 7]));
        chk($sformatf("%s_dp%0d", nm, i),
            32'(dp_s), 32'(e.dpn[i]));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] ea;
    logic [6:0] es;

    vt[0]  = '{1'b0, 1'b0, 16'd255,   4'b0000, {BL, S2, S5, S5}, 1'b0, 9};
    vt[1]  = '{1'b0, 1'b1, 16'h00A7,  4'b0010, {BL, BL, SA, S7}, 1'b0, 0};
    vt[2]  = '{1'b0, 1'b0, 16'd0,     4'b0001, {BL, BL, BL, S0}, 1'b0, 9};
    vt[3]  = '{1'b0, 1'b0, 16'd42,    4'b1000, {BL, BL, S4, S2}, 1'b0, 9};
    vt[4]  = '{1'b0, 1'b1, 16'h00FF,  4'b0000, {BL, BL, SF, SF}, 1'b0, 0};
    vt[5]  = '{1'b0, 1'b1, 16'h0030,  4'b0100, {BL, BL, S3, S0}, 1'b0, 0};
    vt[6]  = '{1'b0, 1'b0, 16'd200,   4'b0000, {BL, S2, S0, S0}, 1'b0, 9};
    vt[7]  = '{1'b0, 1'b0, 16'd9,     4'b0000, {BL, BL, BL, S9}, 1'b0, 9};
    vt[8]  = '{1'b1, 1'b0, 16'd12345, 4'b0101, {DS, DS, DS, DS}, 1'b1, 17};
    vt[9]  = '{1'b1, 1'b0, 16'd9999,  4'b0000, {S9, S9, S9, S9}, 1'b0, 17};
    vt[10] = '{1'b1, 1'b0, 16'd10000, 4'b0000, {DS, DS, DS, DS}, 1'b1, 17};
    vt[11] = '{1'b1, 1'b1, 16'hBEEF,  4'b1001, {SB, SE, SE, SF}, 1'b0, 0};
    vt[12] = '{1'b1, 1'b0, 16'd1000,  4'b0000, {S1, S0, S0, S0}, 1'b0, 17};
    vt[13] = '{1'b1, 1'b1, 16'h00C5,  4'b0000, {BL, BL, SC, S5}, 1'b0, 0};

    sel = 1'b0;
    dp_in = 4'b0000;
    b8.load = 1'b0;  b8.hex_mode = 1'b0;  b8.data = '0;
    b16.load = 1'b0; b16.hex_mode = 1'b0; b16.data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_busy8", 32'(b8.busy), 32'd0);
    chk("rst_ovf8", 32'(b8.overflow), 32'd0);
    chk("rst_busy16", 32'(b16.busy), 32'd0);
    for (int c = 0; c < 24; c++) begin
      if (c < 4) begin
        ea = 4'b1111;
        es = BL;
      end else begin
        ea = ~(4'b0001 << (((c - 4) / 4) % 4));
        es = (ea == 4'b1110) ? S0 : BL;
      end
      chk($sformatf("scan_c%0d", c),
          32'({an_s, seg_s, dp_s}), 32'({ea, es, 1'b1}));
      @(negedge clk);
    end

    for (int v = 0; v < 14; v++) begin
      dp_in = vt[v].dpi;
      sbq.push_back('{vt[v].s, vt[v].segs, ~vt[v].dpi, vt[v].ovf});
      do_load(vt[v].s, vt[v].h, vt[v].d);
      wait_idle(n);
      chk($sformatf("v%0d_busy_cycles", v), 32'(n), 32'(vt[v].bz));
      check_disp($sformatf("v%0d", v));
    end

    dp_in = 4'b0000;
    sel = 1'b0;
    sbq.push_back('{1'b0, {BL, S1, S0, S0}, 4'b1111, 1'b0});
    @(negedge clk);
    b8.data = 8'd100; b8.hex_mode = 1'b0; b8.load = 1'b1;
    @(negedge clk);
    b8.load = 1'b0;
    @(negedge clk);
    b8.data = 8'd42; b8.load = 1'b1;
    @(negedge clk);
    b8.load = 1'b0;
    wait_idle(n);
    check_disp("ignore");

    do_load(1'b0, 1'b0, 16'd255);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(b8.busy), 32'd1);
    rst = 1'b1;
    b8.data = 8'd77; b8.hex_mode = 1'b0; b8.load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b8.load = 1'b0;
    chk("abort_busy", 32'(b8.busy), 32'd0);
    chk("abort_pins", 32'({an8, seg8, dp8}), 32'({4'b1111, BL, 1'b1}));
    chk("abort_ovf", 32'(b8.overflow), 32'd0);
    @(negedge clk);
    chk("abort_load_ign", 32'(b8.busy), 32'd0);
    sbq.push_back('{1'b0, {BL, BL, BL, S0}, 4'b1111, 1'b0});
    check_disp("abort_zero");
    sbq.push_back('{1'b0, {BL, BL, S3, S7}, 4'b1111, 1'b0});
    do_load(1'b0, 1'b0, 16'd37);
    wait_idle(n);
    chk("fresh_busy_cycles", 32'(n), 32'd9);
    check_disp("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
